// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // Bit counter width; it counts down from w-1 to 0.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/bit_compare_cell.sv
// One-bit greater/lesser/equal decision; invert swaps GT/LT for a sign bit.
module bit_compare_cell
  import cmp_pkg::*;
(
  input  logic       pa,
  input  logic       pb,
  input  logic       invert,
  output logic [1:0] verdict_c
);

  always_comb begin
    verdict_c = CMP_EQ;
    if (pa && !pb) begin
      verdict_c = invert ? CMP_LT : CMP_GT;
    end else if (!pa && pb) begin
      verdict_c = invert ? CMP_GT : CMP_LT;
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial W-bit magnitude comparator, MSB first, with start/busy/done handshake.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter bit          SIGNED     = 1'b0,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         greater,
  output logic         lesser,
  output logic         equal
);

  localparam int unsigned     CNT_W    = cnt_width(W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W - 1);

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_a_sh, w_a_sh_nxt;
  logic [W-1:0]     r_b_sh, w_b_sh_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_verdict, w_verdict_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_gt, w_gt_nxt;
  logic             r_lt, w_lt_nxt;
  logic             r_eq, w_eq_nxt;

  logic             w_first;
  logic             w_last;
  logic             w_invert;
  logic [1:0]       w_bit_v;
  logic [1:0]       w_verdict_now;
  logic             w_finish;

  assign w_first  = (r_cnt == CNT_LOAD);
  assign w_last   = (r_cnt == '0);
  assign w_invert = SIGNED && w_first;

  bit_compare_cell u_cell (
    .pa       (r_a_sh[W-1]),
    .pb       (r_b_sh[W-1]),
    .invert   (w_invert),
    .verdict_c(w_bit_v)
  );

  // A verdict already fixed by an earlier bit is never overridden.
  assign w_verdict_now = (r_verdict != CMP_EQ) ? r_verdict : w_bit_v;
  assign w_finish      = w_last || (EARLY_EXIT && (w_bit_v != CMP_EQ));

  always_comb begin
    w_state_nxt   = r_state;
    w_a_sh_nxt    = r_a_sh;
    w_b_sh_nxt    = r_b_sh;
    w_cnt_nxt     = r_cnt;
    w_verdict_nxt = r_verdict;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_gt_nxt      = r_gt;
    w_lt_nxt      = r_lt;
    w_eq_nxt      = r_eq;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt   = RUN;
          w_a_sh_nxt    = a;
          w_b_sh_nxt    = b;
          w_cnt_nxt     = CNT_LOAD;
          w_verdict_nxt = CMP_EQ;
          w_busy_nxt    = 1'b1;
          w_gt_nxt      = 1'b0;
          w_lt_nxt      = 1'b0;
          w_eq_nxt      = 1'b0;
        end
      end
      RUN: begin
        w_verdict_nxt = w_verdict_now;
        if (w_finish) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_gt_nxt    = (w_verdict_now == CMP_GT);
          w_lt_nxt    = (w_verdict_now == CMP_LT);
          w_eq_nxt    = (w_verdict_now == CMP_EQ);
        end else begin
          w_a_sh_nxt = {r_a_sh[W-2:0], 1'b0};
          w_b_sh_nxt = {r_b_sh[W-2:0], 1'b0};
          w_cnt_nxt  = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_cnt     <= '0;
      r_verdict <= CMP_EQ;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_a_sh    <= w_a_sh_nxt;
      r_b_sh    <= w_b_sh_nxt;
      r_cnt     <= w_cnt_nxt;
      r_verdict <= w_verdict_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_gt      <= w_gt_nxt;
      r_lt      <= w_lt_nxt;
      r_eq      <= w_eq_nxt;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign greater = r_gt;
  assign lesser  = r_lt;
  assign equal   = r_eq;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: three comparator configurations (unsigned/early, signed/early, unsigned/constant-time).
module tb_serial_magnitude_comparator;

  typedef struct {
    logic [2:0] v;    // {greater, lesser, equal}
    int         lat;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start [3];
  logic [7:0] a_in  [3];
  logic [7:0] b_in  [3];
  logic       busy  [3];
  logic       done  [3];
  logic       gt    [3];
  logic       lt    [3];
  logic       eq    [3];

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  serial_magnitude_comparator #(.W(8), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u_dut_ue (
    .clk(clk), .rst(rst), .start(start[0]), .a(a_in[0]), .b(b_in[0]),
    .busy(busy[0]), .done(done[0]), .greater(gt[0]), .lesser(lt[0]), .equal(eq[0])
  );

  serial_magnitude_comparator #(.W(8), .SIGNED(1'b1), .EARLY_EXIT(1'b1)) u_dut_se (
    .clk(clk), .rst(rst), .start(start[1]), .a(a_in[1]), .b(b_in[1]),
    .busy(busy[1]), .done(done[1]), .greater(gt[1]), .lesser(lt[1]), .equal(eq[1])
  );

  serial_magnitude_comparator #(.W(8), .SIGNED(1'b0), .EARLY_EXIT(1'b0)) u_dut_uc (
    .clk(clk), .rst(rst), .start(start[2]), .a(a_in[2]), .b(b_in[2]),
    .busy(busy[2]), .done(done[2]), .greater(gt[2]), .lesser(lt[2]), .equal(eq[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: verdict from a parallel compare, latency from the first differing bit.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input bit sgn, input bit ee);
    exp_t e;
    bit   found;
    if (sgn) begin
      if ($signed(x) > $signed(y))      e.v = 3'b100;
      else if ($signed(x) < $signed(y)) e.v = 3'b010;
      else                              e.v = 3'b001;
    end else begin
      if (x > y)      e.v = 3'b100;
      else if (x < y) e.v = 3'b010;
      else            e.v = 3'b001;
    end
    e.lat = 8;
    found = 1'b0;
    if (ee) begin
      for (int i = 7; i >= 0; i--) begin
        if (!found && (x[i] != y[i])) begin
          e.lat = 8 - i;
          found = 1'b1;
        end
      end
    end
    return e;
  endfunction

  // Called at a negedge: present a start and record the expected outcome.
  task automatic drive_start(input int d, input logic [7:0] x, input logic [7:0] y);
    start[d] = 1'b1;
    a_in[d]  = x;
    b_in[d]  = y;
    sb.push_back(model(x, y, d == 1, d != 2));
  endtask

  // Accepting edge, then wait (bounded) for done; glitch>0 pulses start at that edge.
  task automatic collect(input int d, input int glitch);
    exp_t e;
    int   lat;
    bit   seen;
    @(posedge clk);
    @(negedge clk);
    start[d] = 1'b0;
    check("accept_state", {27'd0, busy[d], done[d], gt[d], lt[d], eq[d]}, 32'b10000);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (lat + 1 == glitch) begin
        start[d] = 1'b1;
        a_in[d]  = ~a_in[d];
        b_in[d]  = ~b_in[d];
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == glitch) start[d] = 1'b0;
      if (done[d]) seen = 1'b1;
    end
    e = sb.pop_front();
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", lat, e.lat);
    check("verdict", {28'd0, busy[d], gt[d], lt[d], eq[d]}, {28'd0, 1'b0, e.v});
  endtask

  initial begin
    bit         got_done;
    logic [7:0] x;
    logic [7:0] y;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      a_in[i]  = '0;
      b_in[i]  = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_state", {27'd0, busy[i], done[i], gt[i], lt[i], eq[i]}, 32'd0);
    end
    rst = 1'b0;

    // Unsigned, early exit
    @(negedge clk); drive_start(0, 8'hA5, 8'h5A); collect(0, 0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done[0]}, 32'd0);
    drive_start(0, 8'h3C, 8'h3D); collect(0, 3);
    @(negedge clk); drive_start(0, 8'h7E, 8'h7E); collect(0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("verdict_hold", {28'd0, done[0], gt[0], lt[0], eq[0]}, 32'b0001);
    end

    // Signed, early exit
    @(negedge clk); drive_start(1, 8'h80, 8'h01); collect(1, 0);
    @(negedge clk); drive_start(1, 8'h01, 8'hFF); collect(1, 0);
    @(negedge clk); drive_start(1, 8'hFE, 8'hFF); collect(1, 0);

    // Constant time, second start in the done cycle
    @(negedge clk); drive_start(2, 8'hA5, 8'h5A); collect(2, 0);
    drive_start(2, 8'h00, 8'h00); collect(2, 0);

    // Random pairs, often differing in a single bit
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 6; k++) begin
        x = 8'($urandom);
        y = (k % 2 == 0) ? 8'(x ^ (8'h01 << $urandom_range(0, 7))) : 8'($urandom);
        @(negedge clk); drive_start(d, x, y); collect(d, 0);
      end
    end

    // Reset in the middle of a compare
    @(negedge clk);
    start[0] = 1'b1;
    a_in[0]  = 8'h01;
    b_in[0]  = 8'h02;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {27'd0, busy[0], done[0], gt[0], lt[0], eq[0]}, 32'd0);
    got_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done[0]) got_done = 1'b1;
    end
    check("abort_no_done", {31'd0, got_done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Bit-serial N-bit magnitude comparator. Consumes two W-bit operands and examines one bit pair per clock, MSB first.
- Each step is the 1-bit greater/lesser/equal decision. The per-bit verdicts combine into a registered word-level verdict.
- Sits downstream of the team's 1-bit compare primitive. Provides a start/busy/done handshake to control logic that needs word compares without a W-bit parallel comparator.

Parameters:
- W, 8, operand width in bits; legal range 2..32.
- SIGNED, 0, 1 = two's-complement compare; 0 = unsigned.
- EARLY_EXIT, 1, 1 = finish at the first differing bit; 0 = always take W cycles (constant time).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a compare; sampled only when busy=0
- a  input  W  operand A; captured on the accepted start edge
- b  input  W  operand B; captured on the accepted start edge
- busy  output  1  compare in progress
- done  output  1  one-cycle pulse; verdict valid from this cycle
- greater  output  1  A > B
- lesser  output  1  A < B
- equal  output  1  A == B

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset: state IDLE, busy=0, done=0, greater=lesser=equal=0, shift registers and counter cleared.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - a and b load into shift registers a_sh and b_sh; the bit counter loads W-1; the internal verdict clears to "equal so far".
  - greater/lesser/equal clear to 0; busy=1 after E0.
- RUN, each cycle: compare bit pair pa=a_sh[W-1], pb=b_sh[W-1].
  - Unsigned, or any bit other than the first: pa=1,pb=0 -> greater; pa=0,pb=1 -> lesser; else equal.
  - SIGNED=1 and first (sign) bit: the verdict is inverted. pa=1,pb=0 -> lesser; pa=0,pb=1 -> greater.
  - The first differing bit fixes the verdict. Later bits never change it.
- Finish conditions:
  - EARLY_EXIT=1: finish on the edge where a difference is seen, or where counter==0.
  - EARLY_EXIT=0: finish only where counter==0.
  - If not finishing: shift both registers left by 1 and decrement the counter.
- On the finish edge:
  - The state returns to IDLE.
  - busy=0 and done=1 for exactly one cycle.
  - Exactly one of greater/lesser/equal becomes 1.
- Latency, counted in edges from E0 to the edge after which done=1:
  - EARLY_EXIT=1: k+1, where k = number of equal leading bits; all-equal operands take W.
  - EARLY_EXIT=0: always W.
- Verdict outputs hold until the next accepted start or reset. They are never all-0 while done has been seen and no new start has occurred.
- start while busy=1 is ignored, with no effect on operands or timing.
- start in the done cycle is accepted, because the FSM is already in IDLE. That start clears the verdict on the same edge.
- a and b may change freely while busy; only the captured copies are used.
- rst during RUN aborts the compare: no done pulse, all outputs return to their reset values on that edge.
- rst and start together: rst wins.

Decomposition:
- Shared package cmp_pkg holds:
  - the state enum (IDLE, RUN);
  - the verdict encoding as 2-bit constants: CMP_EQ=2'b00, CMP_GT=2'b01, CMP_LT=2'b10;
  - a helper function returning the counter width $clog2(W).
- One sub-module is natural: bit_compare_cell.
  - Purely combinational.
  - Inputs pa, pb, invert.
  - Output: the 2-bit verdict.
  - Instantiated once. invert = SIGNED && first_bit.

Test Plan:
- W=8, unsigned, EARLY_EXIT=1; start with a=0xA5, b=0x5A -> busy=1 for 1 cycle; done after 1 edge; greater=1, lesser=0, equal=0.
- a=0x3C, b=0x3D -> done after 8 edges; lesser=1. A start pulse at edge 3 is ignored: the verdict is unchanged and done still occurs at edge 8.
- a=b=0x7E -> done after 8 edges; equal=1. Verdict held for 20 idle cycles. A new start clears it to 000 on the accepting edge.
- SIGNED=1: a=0x80 (-128), b=0x01 -> lesser=1 after 1 edge. Then a=0x01, b=0xFF (-1) -> greater=1 after 1 edge. Then a=0xFE, b=0xFF -> lesser=1 after 8 edges.
- EARLY_EXIT=0: a=0xA5, b=0x5A -> done exactly 8 edges after start; greater=1. Back-to-back start asserted in the done cycle with a=0x00, b=0x00 -> accepted; equal=1 after 8 more edges.
- rst asserted 3 edges into a compare of a=0x01, b=0x02 -> next cycle busy=0, done=0, all verdict outputs 0. No done pulse for 10 cycles afterwards.
